// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared arbitration modes, FSM states and id width helper
package bus_arb_pkg;
    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
    typedef enum logic {IDLE, LOCKED} arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: N upstream request channels plus one registered follower channel
interface bus_rr_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int ID_WIDTH    = id_width(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0]                 s_valid;
    logic [NUM_MASTERS-1:0]                 s_ready;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_addr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_data;
    logic [NUM_MASTERS-1:0]                 s_write_enable;
    logic [NUM_MASTERS-1:0]                 s_last;
    logic                                   m_valid;
    logic                                   m_ready;
    logic [ADDR_WIDTH-1:0]                  m_addr;
    logic [DATA_WIDTH-1:0]                  m_data;
    logic                                   m_write_enable;
    logic                                   m_last;
    logic [ID_WIDTH-1:0]                    m_id;

    modport slave (
        input  s_valid, s_addr, s_data, s_write_enable, s_last, m_ready,
        output s_ready, m_valid, m_addr, m_data, m_write_enable, m_last, m_id
    );

    modport master (
        output s_valid, s_addr, s_data, s_write_enable, s_last, m_ready,
        input  s_ready, m_valid, m_addr, m_data, m_write_enable, m_last, m_id
    );
endinterface

// File: rtl/bus_arb_pick.sv
// bus_arb_pick: picks one requester, searching from ptr (round-robin) or from 0 (fixed)
module bus_arb_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]    ptr,
    input  arb_mode_e              mode,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_WIDTH-1:0]    winner
);
    int   idx;
    logic found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (mode == ARB_FIXED) ? k : (int'(ptr) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = ID_WIDTH'(idx);
            end
        end
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: N-to-1 valid/ready arbiter with burst locking and a registered output stage
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int        NUM_MASTERS = 4,
    parameter int        ADDR_WIDTH  = 32,
    parameter int        DATA_WIDTH  = 8,
    parameter arb_mode_e ARB_MODE    = ARB_RR,
    parameter int        ID_WIDTH    = id_width(NUM_MASTERS)
) (
    input logic             clk,
    input logic             rst,
    bus_rr_arbiter_if.slave bus
);
    arb_state_e             state, state_n;
    logic [ID_WIDTH-1:0]    ptr, lock_id, win, pick_win;
    logic [NUM_MASTERS-1:0] pick_gnt, lock_gnt, grant;
    logic                   can_load, accept, last;
    logic [ADDR_WIDTH-1:0]  addr_w;
    logic [DATA_WIDTH-1:0]  data_w;

    bus_arb_pick #(.NUM_MASTERS(NUM_MASTERS), .ID_WIDTH(ID_WIDTH)) u_pick (
        .req    (bus.s_valid),
        .ptr    (ptr),
        .mode   (ARB_MODE),
        .grant  (pick_gnt),
        .winner (pick_win)
    );

    // While locked only the burst owner may be granted, even if it idles
    always_comb begin
        lock_gnt          = '0;
        lock_gnt[lock_id] = bus.s_valid[lock_id];
        grant             = (state == LOCKED) ? lock_gnt : pick_gnt;
        win               = (state == LOCKED) ? lock_id : pick_win;
        can_load          = !bus.m_valid || bus.m_ready;
        bus.s_ready       = (rst && can_load) ? grant : '0;
        accept            = |(bus.s_ready & bus.s_valid);
        last              = bus.s_last[win];
        addr_w            = bus.s_addr[win];
        data_w            = bus.s_data[win];
        state_n           = accept ? (last ? IDLE : LOCKED) : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= IDLE;
            ptr                <= '0;
            lock_id            <= '0;
            bus.m_valid        <= 1'b0;
            bus.m_addr         <= '0;
            bus.m_data         <= '0;
            bus.m_write_enable <= 1'b0;
            bus.m_last         <= 1'b0;
            bus.m_id           <= '0;
        end else begin
            state <= state_n;
            if (accept && last && ARB_MODE == ARB_RR)
                ptr <= (win == ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
            if (accept) begin
                lock_id            <= win;
                bus.m_valid        <= 1'b1;
                bus.m_addr         <= addr_w;
                bus.m_data         <= data_w;
                bus.m_write_enable <= bus.s_write_enable[win];
                bus.m_last         <= last;
                bus.m_id           <= win;
            end else if (bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: table-driven round-robin checks with a beat scoreboard, plus a fixed-priority sequence
module tb_bus_rr_arbiter;
    import bus_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int NV = 23;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic       mr;
        logic [3:0] er;
        logic       mv;
    } vec_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   vectors = 0;
    int   errors  = 0;
    int   beat[N];
    logic prev_rst;
    vec_t tv[NV];
    beat_t q[$];
    beat_t b;

    always #5 clk = ~clk;

    bus_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
    bus_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

    bus_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_RR)) u_rr (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if.slave)
    );

    bus_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_FIXED)) u_fix (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    function automatic logic [AW-1:0] addr_of(input int i, input int n);
        return (AW'(32'h40) << i) + AW'(4 * n);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i, input int n);
        return DW'(i * 16 + n);
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic mr, input logic [3:0] er, input logic mv);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.mr = mr; t.er = er; t.mv = mv;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_a(input vec_t t);
        rst_a          = t.rst;
        a_if.s_valid   = t.v;
        a_if.s_last    = t.l;
        a_if.m_ready   = t.mr;
        for (int i = 0; i < N; i++) begin
            a_if.s_addr[i]         = addr_of(i, beat[i]);
            a_if.s_data[i]         = data_of(i, beat[i]);
            a_if.s_write_enable[i] = (i % 2) == 1;
        end
    endtask

    initial begin
        // Reset / fairness
        tv[0]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0);
        tv[1]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0);
        tv[2]  = mk(1, 4'b1111, 4'b1111, 1, 4'b0001, 0);
        tv[3]  = mk(1, 4'b1111, 4'b1111, 1, 4'b0010, 1);
        tv[4]  = mk(1, 4'b1111, 4'b1111, 1, 4'b0100, 1);
        tv[5]  = mk(1, 4'b1111, 4'b1111, 1, 4'b1000, 1);
        tv[6]  = mk(1, 4'b1111, 4'b1111, 1, 4'b0001, 1);
        tv[7]  = mk(1, 4'b1111, 4'b1111, 1, 4'b0010, 1);
        // Burst lock on master 2 while master 0 waits
        tv[8]  = mk(1, 4'b0101, 4'b0001, 1, 4'b0100, 1);
        tv[9]  = mk(1, 4'b0101, 4'b0001, 1, 4'b0100, 1);
        tv[10] = mk(1, 4'b0101, 4'b0101, 1, 4'b0100, 1);
        tv[11] = mk(1, 4'b0001, 4'b0001, 1, 4'b0001, 1);
        // Backpressure
        tv[12] = mk(1, 4'b0001, 4'b0001, 0, 4'b0000, 1);
        tv[13] = mk(1, 4'b0001, 4'b0001, 0, 4'b0000, 1);
        tv[14] = mk(1, 4'b0001, 4'b0001, 0, 4'b0000, 1);
        tv[15] = mk(1, 4'b0001, 4'b0001, 1, 4'b0001, 1);
        tv[16] = mk(1, 4'b0000, 4'b0001, 1, 4'b0000, 1);
        tv[17] = mk(1, 4'b0000, 4'b0001, 1, 4'b0000, 0);
        // Reset in the middle of a master 1 burst
        tv[18] = mk(1, 4'b0011, 4'b0001, 1, 4'b0010, 0);
        tv[19] = mk(0, 4'b0011, 4'b0001, 0, 4'b0000, 1);
        tv[20] = mk(1, 4'b0001, 4'b0001, 1, 4'b0001, 0);
        tv[21] = mk(1, 4'b0000, 4'b0001, 1, 4'b0000, 1);
        tv[22] = mk(1, 4'b0000, 4'b0001, 1, 4'b0000, 0);

        for (int i = 0; i < N; i++) beat[i] = 0;
        rst_b                = 1'b0;
        b_if.s_valid         = '0;
        b_if.s_last          = '1;
        b_if.m_ready         = 1'b0;
        for (int i = 0; i < N; i++) begin
            b_if.s_addr[i]         = addr_of(i, 0);
            b_if.s_data[i]         = data_of(i, 0);
            b_if.s_write_enable[i] = (i % 2) == 1;
        end
        apply_a(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 0));
        @(posedge clk);
        prev_rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            apply_a(tv[k]);
            #1;
            chk($sformatf("s_ready[%0d]", k), 64'(a_if.s_ready), 64'(tv[k].er));
            chk($sformatf("m_valid[%0d]", k), 64'(a_if.m_valid), 64'(tv[k].mv));
            if (!prev_rst)
                chk($sformatf("rst_zero[%0d]", k),
                    64'({a_if.m_addr, a_if.m_data, a_if.m_id, a_if.m_write_enable, a_if.m_last}), 64'(0));
            if (tv[k].rst && a_if.m_valid) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL sb_empty[%0d]: got beat id %0d expected none", k, a_if.m_id);
                end else begin
                    b = q[0];
                    chk($sformatf("m_id[%0d]", k), 64'(a_if.m_id), 64'(b.id));
                    chk($sformatf("m_addr[%0d]", k), 64'(a_if.m_addr), 64'(b.addr));
                    chk($sformatf("m_data[%0d]", k), 64'(a_if.m_data), 64'(b.data));
                    chk($sformatf("m_we_last[%0d]", k), 64'({a_if.m_write_enable, a_if.m_last}),
                        64'({b.we, b.last}));
                    if (a_if.m_ready) void'(q.pop_front());
                end
            end
            if (!tv[k].rst) q.delete();
            for (int i = 0; i < N; i++) begin
                if (tv[k].er[i]) begin
                    b.id   = IW'(i);
                    b.addr = addr_of(i, beat[i]);
                    b.data = data_of(i, beat[i]);
                    b.we   = (i % 2) == 1;
                    b.last = tv[k].l[i];
                    q.push_back(b);
                    beat[i]++;
                end
            end
            prev_rst = tv[k].rst;
        end
        if (q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL sb_leftover: got %0d pending beats expected 0", q.size());
        end

        // Fixed priority: master 1 starves master 3 until it drops
        @(negedge clk);
        rst_b        = 1'b1;
        b_if.s_valid = 4'b1010;
        b_if.m_ready = 1'b1;
        #1 chk("fx_ready0", 64'(b_if.s_ready), 64'(4'b0010));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("fx_mv", 64'(b_if.m_valid), 64'(1));
            chk("fx_id1", 64'(b_if.m_id), 64'(1));
            chk("fx_ready", 64'(b_if.s_ready), 64'(4'b0010));
        end
        @(negedge clk);
        b_if.s_valid = 4'b1000;
        #1;
        chk("fx_ready3", 64'(b_if.s_ready), 64'(4'b1000));
        chk("fx_id1_last", 64'(b_if.m_id), 64'(1));
        @(negedge clk);
        b_if.s_valid = 4'b0000;
        #1;
        chk("fx_id3", 64'(b_if.m_id), 64'(3));
        chk("fx_addr3", 64'(b_if.m_addr), 64'(addr_of(3, 0)));
        chk("fx_ready_none", 64'(b_if.s_ready), 64'(0));
        @(negedge clk);
        #1 chk("fx_mv_drop", 64'(b_if.m_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Parametrised N-to-1 request arbiter for the valid/ready bus used by `bus_if` masters and followers.
- Merges NUM_MASTERS master request channels (addr, data, write_enable) onto one follower channel.
- Supports round-robin or fixed-priority arbitration, burst locking via a last flag, and a fully registered output stage.
- Replaces the ad hoc single-master follower wiring in top-level test modules.

Parameters:
- NUM_MASTERS, 4, number of upstream master channels (≥1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 8, payload width (matches test_pkg::data_t default).
- ARB_MODE, ARB_RR, arbitration mode (bus_arb_pkg::arb_mode_e: ARB_RR round-robin, ARB_FIXED lowest index wins).
- ID_WIDTH, (NUM_MASTERS>1 ? $clog2(NUM_MASTERS) : 1), derived; width of the source index.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-low.
- s_valid  input  [NUM_MASTERS]  per-master request valid.
- s_ready  output  [NUM_MASTERS]  per-master accept.
- s_addr  input  [NUM_MASTERS][ADDR_WIDTH]  per-master address.
- s_data  input  [NUM_MASTERS][DATA_WIDTH]  per-master write data.
- s_write_enable  input  [NUM_MASTERS]  per-master write flag.
- s_last  input  [NUM_MASTERS]  final beat of a burst; single beats carry 1.
- m_valid  output  1  follower-side valid.
- m_ready  input  1  follower-side ready.
- m_addr  output  ADDR_WIDTH  registered address.
- m_data  output  DATA_WIDTH  registered data.
- m_write_enable  output  1  registered write flag.
- m_last  output  1  registered last flag.
- m_id  output  ID_WIDTH  index of the master that sourced the current beat.

Behaviour:
- Reset (rst==0 at posedge):
  - m_valid, m_addr, m_data, m_write_enable, m_last and m_id are all 0.
  - State is IDLE and the RR pointer is 0.
  - s_ready is forced to 0 combinationally while rst==0.
- Handshakes:
  - A transfer occurs when valid&&ready in the same cycle.
  - Upstream payload is sampled only on s_valid[i]&&s_ready[i].
- Output register:
  - can_load = !m_valid || m_ready.
  - s_ready[i] = rst && can_load && grant[i].
  - grant is one-hot or zero.
  - On an accept, all m_* load from the winner and m_valid=1 on the next cycle, so latency is 1 cycle.
  - If m_ready && !accept, m_valid=0.
  - Full throughput: one beat per cycle with no bubble under continuous m_ready.
  - m_* stay stable while m_valid && !m_ready.
- State machine, IDLE:
  - grant = pick(s_valid, ptr, ARB_MODE).
  - On accept with s_last=0: go to LOCKED and record lock_id = winner.
  - On accept with s_last=1: stay IDLE.
- State machine, LOCKED:
  - grant = one-hot(lock_id) if s_valid[lock_id], else 0.
  - Other masters are never granted, even when the locked master idles.
  - On accept with s_last=1: go to IDLE.
- RR pointer:
  - Only in ARB_RR.
  - On each accepted beat with s_last=1: ptr = (winner+1) mod NUM_MASTERS.
  - The search order is ptr, ptr+1, …, wrapping at NUM_MASTERS-1 → 0.
  - No update on non-last beats.
- Fixed mode: lowest-index valid wins and ptr is ignored; starvation is permitted.
- NUM_MASTERS=1: degenerates to a registered pass-through; m_id is always 0.
- s_ready does not depend on s_valid of the same master, except through grant.
- Upstream must not drop s_valid before its handshake; a violation is not checked.
- Reset mid-burst: lock is released, state goes to IDLE, ptr goes to 0, and any in-flight m_valid is dropped.

Decomposition:
- bus_arb_pkg holds:
  - arb_mode_e (ARB_RR, ARB_FIXED);
  - arb_state_e (IDLE, LOCKED);
  - function id_width(n).
- One combinational sub-module, bus_arb_pick: inputs req vector, ptr and mode; outputs one-hot grant and binary winner index.
- The top level holds the FSM, the pointer and the output register.

Test Plan (NUM_MASTERS=4, ADDR_WIDTH=32, DATA_WIDTH=8 unless noted):
1. rst=0 for 2 cycles with s_valid=4'b1111 → s_ready=0 and m_valid=0; m_addr/m_data/m_id are 0 throughout.
2. Fairness: all masters continuously valid with single beats (s_last=1), m_ready=1 → m_id runs 0,1,2,3,0,1 on consecutive cycles; m_valid stays high from the first cycle after the first accept.
3. Burst lock: master 2 sends addr 0x100/0x104/0x108 with s_last=0,0,1 while master 0 holds valid → m_id=2 for 3 consecutive beats with addresses in order, then m_id=0.
4. Backpressure: m_valid=1, m_addr=0x40, m_ready=0 for 3 cycles → m_addr/m_data stable and s_ready all 0; m_ready=1 → the next beat appears the following cycle, no bubble.
5. ARB_MODE=ARB_FIXED, masters 1 and 3 valid with single beats → m_id=1 on every beat until s_valid[1] drops, then m_id=3.
6. Master 1 locked after beat 1 of 3; rst=0 for 1 cycle with master 0 valid → m_valid=0 after reset; the first grant goes to master 0 with m_id=0.
